// File: rtl/taillight_pkg.sv
// Shared definitions for the tail-light sequencer.
// Holds the sequencer state encoding, the lamp pattern constants, the
// synchronized-switch bundle and small helpers that map states to lamp patterns.
package taillight_pkg;

  localparam int unsigned LAMP_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_L1     = 3'd1,
    ST_L2     = 3'd2,
    ST_L3     = 3'd3,
    ST_R1     = 3'd4,
    ST_R2     = 3'd5,
    ST_R3     = 3'd6,
    ST_HAZ_ON = 3'd7
  } state_t;

  localparam logic [LAMP_W-1:0] PAT_OFF = 3'b000;
  localparam logic [LAMP_W-1:0] PAT_1   = 3'b001;
  localparam logic [LAMP_W-1:0] PAT_2   = 3'b011;
  localparam logic [LAMP_W-1:0] PAT_3   = 3'b111;

  // Synchronized switch levels seen by the sequencer logic.
  typedef struct packed {
    logic left;
    logic right;
    logic hazard;
    logic brake;
  } sw_t;

  // True while the left side is displaying a turn sequence.
  function automatic logic is_left_turn(input state_t s);
    return (s == ST_L1) || (s == ST_L2) || (s == ST_L3);
  endfunction

  // True while the right side is displaying a turn sequence.
  function automatic logic is_right_turn(input state_t s);
    return (s == ST_R1) || (s == ST_R2) || (s == ST_R3);
  endfunction

  // Left lamp pattern for a state, before brake is applied.
  function automatic logic [LAMP_W-1:0] left_pattern(input state_t s);
    case (s)
      ST_L1:     return PAT_1;
      ST_L2:     return PAT_2;
      ST_L3:     return PAT_3;
      ST_HAZ_ON: return PAT_3;
      default:   return PAT_OFF;
    endcase
  endfunction

  // Right lamp pattern for a state, before brake is applied.
  function automatic logic [LAMP_W-1:0] right_pattern(input state_t s);
    case (s)
      ST_R1:     return PAT_1;
      ST_R2:     return PAT_2;
      ST_R3:     return PAT_3;
      ST_HAZ_ON: return PAT_3;
      default:   return PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
// Ports:
//   in_clock - destination clock
//   reset_n  - asynchronous active-low clear of every stage
//   d        - asynchronous input
//   q        - synchronized output, DEPTH cycles behind d
module sync_ff #(
  parameter int unsigned DEPTH = 2
) (
  input  logic in_clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  // Shift the input through DEPTH flops; the oldest stage is the output.
  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/taillight_sequencer.sv
// Tail-light sequencer: left/right turn sweeps, hazard blink and brake overlay.
// Ports:
//   in_clock     - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   step_tick    - one-cycle step enable (synchronous)
//   left_sw      - left-turn switch (asynchronous)
//   right_sw     - right-turn switch (asynchronous)
//   hazard_sw    - hazard switch (asynchronous)
//   brake_sw     - brake switch (asynchronous)
//   left_lights  - left lamps, bit0 innermost (registered)
//   right_lights - right lamps, bit0 innermost (registered)
//   busy         - high whenever the sequencer is not idle (registered)
module taillight_sequencer
  import taillight_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              in_clock,
  input  logic              reset_n,
  input  logic              step_tick,
  input  logic              left_sw,
  input  logic              right_sw,
  input  logic              hazard_sw,
  input  logic              brake_sw,
  output logic [LAMP_W-1:0] left_lights,
  output logic [LAMP_W-1:0] right_lights,
  output logic              busy
);

  sw_t    sw;
  state_t state;
  state_t state_nxt;
  logic [LAMP_W-1:0] left_nxt;
  logic [LAMP_W-1:0] right_nxt;

  // Switch synchronizers; nothing downstream sees the raw inputs.
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_left (
    .in_clock (in_clock),
    .reset_n  (reset_n),
    .d        (left_sw),
    .q        (sw.left)
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_right (
    .in_clock (in_clock),
    .reset_n  (reset_n),
    .d        (right_sw),
    .q        (sw.right)
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_hazard (
    .in_clock (in_clock),
    .reset_n  (reset_n),
    .d        (hazard_sw),
    .q        (sw.hazard)
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_brake (
    .in_clock (in_clock),
    .reset_n  (reset_n),
    .d        (brake_sw),
    .q        (sw.brake)
  );

  // Next-state decode; the state only moves on a step tick.
  always_comb begin
    state_nxt = state;
    if (step_tick) begin
      case (state)
        ST_IDLE: begin
          if (sw.hazard || (sw.left && sw.right)) begin
            state_nxt = ST_HAZ_ON;
          end else if (sw.left) begin
            state_nxt = ST_L1;
          end else if (sw.right) begin
            state_nxt = ST_R1;
          end
        end
        ST_L1:     state_nxt = sw.hazard ? ST_HAZ_ON : ST_L2;
        ST_L2:     state_nxt = sw.hazard ? ST_HAZ_ON : ST_L3;
        ST_L3:     state_nxt = sw.hazard ? ST_HAZ_ON : ST_IDLE;
        ST_R1:     state_nxt = sw.hazard ? ST_HAZ_ON : ST_R2;
        ST_R2:     state_nxt = sw.hazard ? ST_HAZ_ON : ST_R3;
        ST_R3:     state_nxt = sw.hazard ? ST_HAZ_ON : ST_IDLE;
        ST_HAZ_ON: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Lamp decode from the next state so pattern and state update together;
  // brake fills any side that is not sweeping a turn.
  always_comb begin
    left_nxt  = left_pattern(state_nxt);
    right_nxt = right_pattern(state_nxt);
    if (sw.brake) begin
      if (!is_left_turn(state_nxt)) begin
        left_nxt = PAT_3;
      end
      if (!is_right_turn(state_nxt)) begin
        right_nxt = PAT_3;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge in_clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      left_lights  <= PAT_OFF;
      right_lights <= PAT_OFF;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      left_lights  <= left_nxt;
      right_lights <= right_nxt;
      busy         <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_taillight_sequencer.sv
// Scoreboard bench for taillight_sequencer with a behavioural reference model.
module tb_taillight_sequencer;

  logic       in_clock  = 1'b0;
  logic       reset_n   = 1'b1;
  logic       step_tick = 1'b0;
  logic       left_sw   = 1'b0;
  logic       right_sw  = 1'b0;
  logic       hazard_sw = 1'b0;
  logic       brake_sw  = 1'b0;
  logic [2:0] left_lights;
  logic [2:0] right_lights;
  logic       busy;

  taillight_sequencer #(.SYNC_STAGES(2)) dut (
    .in_clock     (in_clock),
    .reset_n      (reset_n),
    .step_tick    (step_tick),
    .left_sw      (left_sw),
    .right_sw     (right_sw),
    .hazard_sw    (hazard_sw),
    .brake_sw     (brake_sw),
    .left_lights  (left_lights),
    .right_lights (right_lights),
    .busy         (busy)
  );

  always #5 in_clock = ~in_clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Expected {busy, left, right} after each rising edge.
  logic [6:0] exp_q[$];
  // Raw switch samples {l,r,h,b}, newest first; the logic acts on the one two edges old.
  logic [3:0] hist[$];

  // Model: mode 0 idle, 1 left sweep, 2 right sweep, 3 hazard on; step = lamps lit.
  int m_mode = 0;
  int m_step = 0;

  function automatic logic [2:0] sweep(input int n);
    return 3'((1 << n) - 1);
  endfunction

  task automatic model_edge();
    logic [3:0] eff;
    logic       l, r, h, b;
    logic [2:0] el, er;
    if (!reset_n) begin
      hist.delete();
      m_mode = 0;
      m_step = 0;
      exp_q.push_back(7'b0);
      return;
    end
    hist.push_front({left_sw, right_sw, hazard_sw, brake_sw});
    if (hist.size() > 3) void'(hist.pop_back());
    eff = (hist.size() == 3) ? hist[2] : 4'b0;
    {l, r, h, b} = eff;
    if (step_tick) begin
      if (m_mode == 0) begin
        if (h || (l && r)) m_mode = 3;
        else if (l) begin m_mode = 1; m_step = 1; end
        else if (r) begin m_mode = 2; m_step = 1; end
      end else if (m_mode == 3) begin
        m_mode = 0;
      end else if (h) begin
        m_mode = 3;
      end else if (m_step == 3) begin
        m_mode = 0;
      end else begin
        m_step = m_step + 1;
      end
    end
    el = (m_mode == 1) ? sweep(m_step) : (m_mode == 3 || b) ? 3'b111 : 3'b000;
    er = (m_mode == 2) ? sweep(m_step) : (m_mode == 3 || b) ? 3'b111 : 3'b000;
    exp_q.push_back({(m_mode != 0), el, er});
  endtask

  initial forever begin
    @(posedge in_clock);
    model_edge();
  end

  // Monitor: compare each registered result half a cycle after it appears.
  initial forever begin
    logic [6:0] e;
    @(negedge in_clock);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({busy, left_lights, right_lights} !== e) begin
        miscompares++;
        $display("FAIL lamps cyc=%0d got busy=%b L=%b R=%b want busy=%b L=%b R=%b",
                 cyc, busy, left_lights, right_lights, e[6], e[5:3], e[2:0]);
      end
    end
  end

  // Advance n cycles; step_tick is a one-cycle pulse every fourth cycle.
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge in_clock);
      step_tick = (cyc % 4 == 0);
      cyc++;
    end
  endtask

  task automatic set_sw(input logic l, input logic r, input logic h, input logic b);
    left_sw   = l;
    right_sw  = r;
    hazard_sw = h;
    brake_sw  = b;
  endtask

  // Wait (bounded) until the model reaches a given sweep position.
  task automatic wait_model(input int mode, input int step, input string name);
    bit hit = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_mode == mode && m_step == step) begin
        hit = 1;
        break;
      end
      cycles(1);
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL %s timeout got mode=%0d step=%0d want mode=%0d step=%0d",
               name, m_mode, m_step, mode, step);
    end
  endtask

  // Asynchronous reset pulse spanning one rising edge, with an immediate output check.
  task automatic pulse_reset(input string name);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if ({busy, left_lights, right_lights} !== 7'b0) begin
      miscompares++;
      $display("FAIL %s got busy=%b L=%b R=%b want all zero",
               name, busy, left_lights, right_lights);
    end
    cycles(1);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    // Power-up reset.
    pulse_reset("reset_init");
    cycles(3);

    // Left held: continuous left sweep.
    set_sw(1, 0, 0, 0);
    cycles(40);
    set_sw(0, 0, 0, 0);
    cycles(20);

    // Right pulsed for about one tick: one sweep, then idle.
    set_sw(0, 1, 0, 0);
    cycles(4);
    set_sw(0, 0, 0, 0);
    cycles(30);

    // Left and right together: hazard-style blink.
    set_sw(1, 1, 0, 0);
    cycles(30);
    set_sw(0, 0, 0, 0);
    cycles(12);

    // Hazard asserted during L2.
    set_sw(1, 0, 0, 0);
    wait_model(1, 2, "reach_l2");
    set_sw(0, 0, 1, 0);
    cycles(10);
    set_sw(0, 0, 0, 0);
    cycles(16);

    // Left with brake, then brake release.
    set_sw(1, 0, 0, 1);
    cycles(40);
    set_sw(1, 0, 0, 0);
    cycles(10);
    set_sw(0, 0, 0, 0);
    cycles(16);

    // Reset during R2, then idle with no switches.
    set_sw(0, 1, 0, 0);
    wait_model(2, 2, "reach_r2");
    set_sw(0, 0, 0, 0);
    pulse_reset("reset_mid_r2");
    cycles(20);

    // Randomized switch activity with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: left_sw   = ~left_sw;
          1: right_sw  = ~right_sw;
          2: hazard_sw = ~hazard_sw;
          default: brake_sw = ~brake_sw;
        endcase
      end
      if ($urandom_range(299) == 0) pulse_reset("reset_random");
      else cycles(1);
    end

    set_sw(0, 0, 0, 0);
    cycles(12);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/taillight_sequencer.md
TAILLIGHT_SEQUENCER -- requirements
Module: taillight_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of each switch-input synchronizer, legal range 2..4.
REQ-002 SHALL have port in_clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port step_tick  input  1  one-cycle step enable from the clock divider, synchronous to in_clock.
REQ-005 SHALL have port left_sw  input  1  left-turn switch, asynchronous, active-high.
REQ-006 SHALL have port right_sw  input  1  right-turn switch, asynchronous, active-high.
REQ-007 SHALL have port hazard_sw  input  1  hazard switch, asynchronous, active-high.
REQ-008 SHALL have port brake_sw  input  1  brake switch, asynchronous, active-high.
REQ-009 SHALL have port left_lights  output  3  left lamps; bit0 innermost, bit2 outermost.
REQ-010 SHALL have port right_lights  output  3  right lamps; bit0 innermost, bit2 outermost.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL pass each *_sw through a SYNC_STAGES-deep synchronizer; all logic uses the synchronized values only.
REQ-013 SHALL implement states IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON; state changes only on cycles with step_tick=1.
REQ-014 From IDLE on tick: hazard or (left and right) -> HAZ_ON; else left -> L1; else right -> R1; else stay IDLE.
REQ-015 L1->L2->L3->IDLE and R1->R2->R3->IDLE on successive ticks regardless of switch state; releasing a turn switch mid-sequence does not abort the sequence.
REQ-016 From any Lx/Rx on tick with hazard asserted: -> HAZ_ON (hazard overrides turn).
REQ-017 HAZ_ON -> IDLE on every tick unconditionally; a held hazard therefore blinks at half the tick rate.
REQ-018 Turn side pattern: state 1 = 001, state 2 = 011, state 3 = 111; IDLE = 000; HAZ_ON = 111 on both sides.
REQ-019 Brake: any side not currently showing a turn pattern shows 111 while brake is asserted; this includes both sides in IDLE and both sides in the off phase of a hazard blink.
REQ-020 Outputs SHALL be registered; a state change and its lamp pattern appear on the same in_clock edge.
REQ-021 A brake change SHALL reach the lamps exactly SYNC_STAGES+1 cycles after the synchronizer input changes, independent of step_tick.
REQ-022 A tick arriving while synchronized switches change in the same cycle SHALL use the synchronized values of that cycle.
REQ-023 A step_tick held high for N cycles SHALL advance the state N times; no edge detection is applied.

Reset
REQ-024 reset_n low SHALL immediately force state=IDLE, left_lights=000, right_lights=000, busy=0, and clear all synchronizer flops, regardless of in_clock.
REQ-025 Reset asserted mid-sequence or mid-hazard SHALL abandon the sequence; after release the block waits in IDLE for the next tick.

Structure
REQ-026 State encoding enum and lamp pattern constants (PAT_OFF=000, PAT_1=001, PAT_2=011, PAT_3=111) SHALL live in shared package taillight_pkg.
REQ-027 The synchronizer SHALL be sub-module sync_ff (parameterized depth, 1 bit wide, async active-low clear), instantiated four times.

Verification
REQ-028 Bench SHALL use SYNC_STAGES=2 and step_tick pulsed 1 cycle every 4 cycles.
REQ-029 left_sw held -> on successive ticks left_lights = 001, 011, 111, 000, 001 ...; right_lights = 000; busy=0 only in IDLE.
REQ-030 right_sw pulsed for 1 tick then released -> right_lights 001, 011, 111, 000, then remains 000.
REQ-031 left_sw and right_sw high together -> both sides 111/000 alternating on each tick.
REQ-032 Sequence state L2, then hazard_sw asserted -> next tick both sides 111, the following tick 000.
REQ-033 left_sw and brake_sw held -> right_lights = 111 constant, left sequence unchanged; brake release -> right_lights 000 exactly 3 cycles later.
REQ-034 reset_n pulsed low during R2 -> all outputs 000 within the same cycle; first tick after release with no switches -> remains IDLE.
